spi_ctrl_rx: RTL and testbench
==============================

Name: spi_ctrl_rx

Overview:
- Control-path receiver ahead of the DSP stage. Accepts 16-bit SPI frames from the MCU and holds the DSP's frequency and scale settings.
- Drives the DSP freqSetting_i / scaleFactor_i inputs directly, with an update strobe and a frame-error flag.
- SPI pins are asynchronous to clk_i. They are oversampled and synchronised; no SPI clock is used as a clock.

Parameters:
- FRAME_W, 16: SPI frame length in bits.
- SYNC_STAGES, 2: synchroniser depth on sck/cs_n/mosi, minimum 2.
- RESET_FREQ, 4'b0001: reset value of freqSetting_o.
- RESET_SCALE, 4'b0001: reset value of scaleFactor_o.

Ports:
- clk_i  in  1  system clock; must be at least 8x the SPI SCK frequency.
- rst_ni  in  1  reset, asynchronous, active-low.
- spiSck_i  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spiCs_ni  in  1  chip select, active-low.
- spiMosi_i  in  1  serial data in, MSB first.
- spiMiso_o  out  1  readback data out.
- freqSetting_o  out  4  to DSP freqSetting_i.
- scaleFactor_o  out  4  to DSP scaleFactor_i.
- settingsChanged_o  out  1  one-cycle pulse when either setting is written.
- frameErr_o  out  1  sticky error flag; cleared by the next good frame.

Behaviour:
- Reset (async assert, sync-released internally):
  - freqSetting_o = RESET_FREQ, scaleFactor_o = RESET_SCALE.
  - settingsChanged_o = 0, frameErr_o = 0, spiMiso_o = 0.
  - Bit count = 0, state = IDLE.
- Synchronisation:
  - Each SPI input passes through SYNC_STAGES flops, plus one extra flop for edge detection.
  - All events below refer to synchronised edges.
- Frame format, MSB first: [15:12] addr, [11:8] reserved (ignored), [7:0] data.
  - addr 4'h1: freqSetting <= data[3:0].
  - addr 4'h2: scaleFactor <= data[3:0].
  - addr 4'h3: freqSetting <= data[7:4] and scaleFactor <= data[3:0].
  - Any other addr is an error. data[7:4] is ignored for addr 1 and 2.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE -> SHIFT on cs_n falling edge. Clear bit count. Load the MISO shift register with {freqSetting, scaleFactor, 8'h00}; drive its MSB on spiMiso_o.
  - SHIFT, sck rising edge: shift mosi into rx register LSB. Increment count, saturating at FRAME_W+1.
  - SHIFT, sck falling edge: shift the MISO register left; spiMiso_o = new MSB.
  - SHIFT -> COMMIT on cs_n rising edge.
  - COMMIT (exactly one cycle) -> IDLE.
    - If count == FRAME_W and addr is valid: update the setting(s), pulse settingsChanged_o for that one cycle, clear frameErr_o.
    - Otherwise: outputs unchanged, frameErr_o <= 1, no pulse.
- Latency: settingsChanged_o and the new outputs appear SYNC_STAGES+2 clk_i cycles after the cs_n pin rises.
  - Outputs change only in COMMIT; they stay stable for the whole frame.
- Boundary conditions:
  - Short frame (<16 bits) or long frame (>16 bits): discarded, frameErr_o = 1.
  - A write of a value equal to the current one still pulses settingsChanged_o.
  - sck and cs_n edges detected in the same cycle: the cs_n edge wins. On cs_n rise, an sck rise in that cycle is not counted. On cs_n fall, sck is ignored that cycle.
  - Reset mid-frame: frame discarded, all outputs return to reset values.
    - If cs_n is already low at reset release, stay in IDLE until cs_n goes high and falls again.
  - spiMiso_o is driven 0 while in IDLE.

Decomposition:
- Shared package spi_ctrl_pkg:
  - addr constants ADDR_FREQ = 4'h1, ADDR_SCALE = 4'h2, ADDR_BOTH = 4'h3.
  - state enum {IDLE, SHIFT, COMMIT}.
  - FRAME_W default.
- One sub-module: spi_sync_edge. Parameterised synchroniser plus rise/fall detect, instantiated for sck, cs_n and mosi (mosi uses the level output only).

Test Plan:
- Reset: hold rst_ni=0 mid-frame, release -> freq=1, scale=1, frameErr=0, no settingsChanged pulse. The rest of that frame is ignored, including with cs_n low at release.
- Frame 16'h1005 -> freqSetting_o=5, scaleFactor_o=1. One-cycle settingsChanged_o exactly SYNC_STAGES+2 cycles after cs_n rises.
- Frame 16'h30A7 -> freq=A, scale=7. Then 16'h2003 -> freq=A, scale=3; two pulses total.
- Errors:
  - 12-bit frame -> frameErr_o=1, outputs unchanged.
  - Then 17-bit frame -> still 1, unchanged.
  - Then 16'h7012 (bad addr) -> still 1, unchanged.
  - Then 16'h1002 -> frameErr_o=0, freq=2.
- Readback: with freq=A and scale=3, send any frame -> the first 8 bits sampled on spiMiso_o at sck rising edges equal 8'hA3, and the remaining bits are 0.
- Fastest legal SCK (clk_i/8) with back-to-back frames (cs_n high for 4 clk_i cycles) -> every frame is committed and no bits are lost.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_ctrl_pkg                                                 |
// | Description : Shared constants, state type and address decode helper for   |
// |               the SPI control-path receiver.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_ctrl_pkg;

  localparam int DEFAULT_FRAME_W = 16;

  localparam logic [3:0] ADDR_FREQ  = 4'h1;
  localparam logic [3:0] ADDR_SCALE = 4'h2;
  localparam logic [3:0] ADDR_BOTH  = 4'h3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic addr_valid(input logic [3:0] addr);
    return (addr == ADDR_FREQ) || (addr == ADDR_SCALE) || (addr == ADDR_BOTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ctrl_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_ctrl_rx_if                                               |
// | Description : SPI pins plus the DSP settings bus of the control receiver.  |
// |   spiSck_i / spiCs_ni / spiMosi_i : SPI mode-0 inputs from the MCU         |
// |   spiMiso_o                       : readback data to the MCU               |
// |   freqSetting_o / scaleFactor_o   : 4-bit settings to the DSP              |
// |   settingsChanged_o / frameErr_o  : update strobe and sticky error flag    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface spi_ctrl_rx_if;
  logic       spiSck_i;
  logic       spiCs_ni;
  logic       spiMosi_i;
  logic       spiMiso_o;
  logic [3:0] freqSetting_o;
  logic [3:0] scaleFactor_o;
  logic       settingsChanged_o;
  logic       frameErr_o;

  // Receiver side
  modport slave (
    input  spiSck_i, spiCs_ni, spiMosi_i,
    output spiMiso_o, freqSetting_o, scaleFactor_o, settingsChanged_o, frameErr_o
  );

  // MCU / DSP side
  modport master (
    output spiSck_i, spiCs_ni, spiMosi_i,
    input  spiMiso_o, freqSetting_o, scaleFactor_o, settingsChanged_o, frameErr_o
  );
endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_sync_edge                                                |
// | Description : Multi-flop synchroniser for one asynchronous input, with a   |
// |               rise/fall detector on the synchronised level.                |
// |   clk, rst_n : system clock, asynchronous active-low reset                 |
// |   i_din      : asynchronous input                                          |
// |   o_level    : synchronised level                                          |
// |   o_rise     : one-cycle pulse on a synchronised 0->1                      |
// |   o_fall     : one-cycle pulse on a synchronised 1->0                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_din,
  output logic      o_level,
  output logic      o_rise,
  output logic      o_fall
);

  if (SYNC_STAGES < 2) begin : g_stage_check
    $error("spi_sync_edge: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_ctrl_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_ctrl_rx                                                  |
// | Description : SPI (mode 0) control receiver holding the DSP frequency and  |
// |               scale settings. SPI pins are oversampled on clk_i.           |
// |   clk_i  : system clock (>= 8x SCK)                                        |
// |   rst_ni : asynchronous active-low reset, released synchronously inside    |
// |   bus    : spi_ctrl_rx_if.slave - SPI pins and DSP settings outputs        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_ctrl_rx
  import spi_ctrl_pkg::*;
#(
  parameter int         FRAME_W     = DEFAULT_FRAME_W,
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] RESET_FREQ  = 4'b0001,
  parameter logic [3:0] RESET_SCALE = 4'b0001
) (
  input wire logic    clk_i,
  input wire logic    rst_ni,
  spi_ctrl_rx_if.slave bus
);

  localparam int                CNT_W      = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  C_CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  C_CNT_SAT  = CNT_W'(FRAME_W + 1);

  // Reset is asserted asynchronously but released on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic w_sck_rise, w_sck_fall, w_sck_level_unused;
  logic w_cs_rise, w_cs_fall, w_cs_level_unused;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk_i), .rst_n(w_rst_n), .i_din(bus.spiSck_i),
    .o_level(w_sck_level_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  // cs_n resets to 0 in the chain: a cs_n already low at reset release
  // produces no falling edge, so a frame starts only after a real high->low.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk(clk_i), .rst_n(w_rst_n), .i_din(bus.spiCs_ni),
    .o_level(w_cs_level_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk_i), .rst_n(w_rst_n), .i_din(bus.spiMosi_i),
    .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  state_t             r_state, w_next;
  logic [FRAME_W-1:0] r_rx;
  logic [FRAME_W-1:0] r_miso_sr;
  logic [CNT_W-1:0]   r_count;
  logic [3:0]         r_freq, r_scale;
  logic               r_changed, r_err;

  logic [3:0]         w_addr;
  logic [7:0]         w_data;
  logic [FRAME_W-9:4] w_rsvd_unused;
  logic               w_frame_ok;

  assign w_addr        = r_rx[FRAME_W-1 -: 4];
  assign w_data        = r_rx[7:0];
  assign w_rsvd_unused = r_rx[FRAME_W-5:8];
  assign w_frame_ok    = (r_count == C_CNT_FULL) && addr_valid(w_addr);

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_next = SHIFT;
      SHIFT:   if (w_cs_rise) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx      <= '0;
      r_miso_sr <= '0;
      r_count   <= '0;
      r_freq    <= RESET_FREQ;
      r_scale   <= RESET_SCALE;
      r_changed <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_rx      <= '0;
            r_count   <= '0;
            r_miso_sr <= {r_freq, r_scale, {(FRAME_W-8){1'b0}}};
          end
        end
        SHIFT: begin
          // A cs_n rise in the same cycle ends the frame; that sck edge is dropped.
          if (!w_cs_rise) begin
            if (w_sck_rise) begin
              r_rx <= {r_rx[FRAME_W-2:0], w_mosi};
              if (r_count != C_CNT_SAT) r_count <= r_count + 1'b1;
            end
            if (w_sck_fall) r_miso_sr <= {r_miso_sr[FRAME_W-2:0], 1'b0};
          end
        end
        COMMIT: begin
          if (w_frame_ok) begin
            r_changed <= 1'b1;
            r_err     <= 1'b0;
            case (w_addr)
              ADDR_FREQ:  r_freq  <= w_data[3:0];
              ADDR_SCALE: r_scale <= w_data[3:0];
              default: begin
                r_freq  <= w_data[7:4];
                r_scale <= w_data[3:0];
              end
            endcase
          end else begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.spiMiso_o         = (r_state == SHIFT) ? r_miso_sr[FRAME_W-1] : 1'b0;
  assign bus.freqSetting_o     = r_freq;
  assign bus.scaleFactor_o     = r_scale;
  assign bus.settingsChanged_o = r_changed;
  assign bus.frameErr_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_ctrl_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_ctrl_rx                                               |
// | Description : Self-checking bench for spi_ctrl_rx. A frame-level model     |
// |               predicts settings, error flag and the update strobe cycle.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_ctrl_rx;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;   // cs_n pin rise to visible outputs, in clk cycles
  localparam int HALF = 4;          // SCK half period in clk cycles (SCK = clk/8)

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_ctrl_rx_if bus ();

  spi_ctrl_rx #(
    .FRAME_W(16), .SYNC_STAGES(SYNC), .RESET_FREQ(4'h1), .RESET_SCALE(4'h1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [3:0]  m_freq  = 4'h1;
  logic [3:0]  m_scale = 4'h1;
  logic        m_err   = 1'b0;
  int          cyc     = 0;
  bit          pend    = 0;
  int          pend_due;
  logic [31:0] pend_bits;
  int          pend_n;
  bit          chk_en  = 0;
  int          pulses  = 0;

  always @(posedge clk) cyc++;

  task automatic model_commit(input logic [31:0] bits, input int n, output logic chg);
    logic [3:0] a;
    logic [7:0] d;
    bit good;
    a = bits[15:12];
    d = bits[7:0];
    good = (n == 16) && (a >= 4'h1) && (a <= 4'h3);
    chg = 1'b0;
    if (good) begin
      if (a == 4'h1) m_freq = d[3:0];
      else if (a == 4'h2) m_scale = d[3:0];
      else begin m_freq = d[7:4]; m_scale = d[3:0]; end
      m_err = 1'b0;
      chg = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  always @(negedge clk) begin : compare
    logic exp_chg;
    exp_chg = 1'b0;
    if (bus.settingsChanged_o === 1'b1) pulses++;
    if (pend && cyc == pend_due) begin
      pend = 0;
      model_commit(pend_bits, pend_n, exp_chg);
    end
    if (chk_en) begin
      check("freq",    32'(bus.freqSetting_o),     32'(m_freq));
      check("scale",   32'(bus.scaleFactor_o),     32'(m_scale));
      check("err",     32'(bus.frameErr_o),        32'(m_err));
      check("changed", 32'(bus.settingsChanged_o), 32'(exp_chg));
    end
  end

  // Sends the low n bits of 'bits', MSB first; captures MISO at each SCK rise.
  task automatic send_frame(input logic [31:0] bits, input int n, input int gap,
                            output logic [15:0] cap);
    cap = '0;
    @(negedge clk);
    bus.spiCs_ni = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.spiMosi_i = bits[i];
      repeat (HALF) @(negedge clk);
      bus.spiSck_i = 1'b1;
      cap = {cap[14:0], bus.spiMiso_o};
      repeat (HALF) @(negedge clk);
      bus.spiSck_i = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    bus.spiCs_ni  = 1'b1;
    bus.spiMosi_i = 1'b0;
    pend_bits = bits;
    pend_n    = n;
    pend_due  = cyc + LAT;
    pend      = 1;
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] cap;
    int p0;
    bus.spiSck_i  = 1'b0;
    bus.spiCs_ni  = 1'b1;
    bus.spiMosi_i = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_freq",  32'(bus.freqSetting_o),     32'h1);
    check("rst_scale", 32'(bus.scaleFactor_o),     32'h1);
    check("rst_err",   32'(bus.frameErr_o),        32'h0);
    check("rst_chg",   32'(bus.settingsChanged_o), 32'h0);
    check("rst_miso",  32'(bus.spiMiso_o),         32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_en = 1;

    // First frame with explicit strobe latency
    send_frame(32'h1005, 16, 1, cap);
    repeat (LAT - 1) @(negedge clk);
    check("lat_before", 32'(bus.settingsChanged_o), 32'h0);
    @(negedge clk);
    check("lat_at",     32'(bus.settingsChanged_o), 32'h1);
    @(negedge clk);
    check("lat_after",  32'(bus.settingsChanged_o), 32'h0);
    repeat (10) @(negedge clk);
    check("f1005_freq",  32'(bus.freqSetting_o), 32'h5);
    check("f1005_scale", 32'(bus.scaleFactor_o), 32'h1);
    check("f1005_pulses", 32'(pulses), 32'd1);

    send_frame(32'h30A7, 16, 20, cap);
    check("f30A7_freq",  32'(bus.freqSetting_o), 32'hA);
    check("f30A7_scale", 32'(bus.scaleFactor_o), 32'h7);
    send_frame(32'h2003, 16, 20, cap);
    check("f2003_scale", 32'(bus.scaleFactor_o), 32'h3);
    check("f2003_pulses", 32'(pulses), 32'd3);

    // Readback, rewriting the same value (must still pulse)
    send_frame(32'h2003, 16, 20, cap);
    check("readback",     32'(cap),    32'hA300);
    check("same_pulses",  32'(pulses), 32'd4);
    check("idle_miso",    32'(bus.spiMiso_o), 32'h0);

    // Error frames
    send_frame(32'h100, 12, 20, cap);
    check("short_err",  32'(bus.frameErr_o),    32'h1);
    check("short_freq", 32'(bus.freqSetting_o), 32'hA);
    send_frame(32'h04006, 17, 20, cap);
    check("long_err",   32'(bus.frameErr_o),    32'h1);
    check("long_scale", 32'(bus.scaleFactor_o), 32'h3);
    send_frame(32'h7012, 16, 20, cap);
    check("badaddr_err",  32'(bus.frameErr_o),    32'h1);
    check("badaddr_freq", 32'(bus.freqSetting_o), 32'hA);
    send_frame(32'h1002, 16, 20, cap);
    check("good_err",    32'(bus.frameErr_o),    32'h0);
    check("good_freq",   32'(bus.freqSetting_o), 32'h2);
    check("good_pulses", 32'(pulses), 32'd5);

    // Reset in the middle of a frame, released with cs_n still low
    @(negedge clk);
    bus.spiCs_ni = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.spiMosi_i = 1'b1;
      repeat (HALF) @(negedge clk); bus.spiSck_i = 1'b1;
      repeat (HALF) @(negedge clk); bus.spiSck_i = 1'b0;
    end
    chk_en = 0;
    rst_n  = 1'b0;
    pend   = 0;
    m_freq = 4'h1; m_scale = 4'h1; m_err = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_freq",  32'(bus.freqSetting_o), 32'h1);
    check("midrst_scale", 32'(bus.scaleFactor_o), 32'h1);
    check("midrst_err",   32'(bus.frameErr_o),    32'h0);
    p0 = pulses;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_en = 1;
    for (int i = 0; i < 10; i++) begin
      bus.spiMosi_i = 1'b1;
      repeat (HALF) @(negedge clk); bus.spiSck_i = 1'b1;
      repeat (HALF) @(negedge clk); bus.spiSck_i = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    bus.spiCs_ni  = 1'b1;
    bus.spiMosi_i = 1'b0;
    repeat (20) @(negedge clk);
    check("postrst_pulses", 32'(pulses), 32'(p0));
    check("postrst_err",    32'(bus.frameErr_o), 32'h0);

    // Back-to-back frames at the fastest SCK, cs_n high for 4 clk cycles
    send_frame(32'h1007, 16, 4, cap);
    send_frame(32'h200C, 16, 4, cap);
    send_frame(32'h3059, 16, 4, cap);
    send_frame(32'h1001, 16, 4, cap);
    send_frame(32'h2005, 16, 20, cap);
    check("b2b_freq",   32'(bus.freqSetting_o), 32'h1);
    check("b2b_scale",  32'(bus.scaleFactor_o), 32'h5);
    check("b2b_pulses", 32'(pulses), 32'(p0 + 5));
    check("b2b_err",    32'(bus.frameErr_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
